// File: rtl/morse_key_decoder_pkg.sv
// Symbol table and FSM encoding shared by the Morse key decoder and the seven-segment decoder.
package morse_pkg;

  localparam logic [5:0] SYM_BLANK  = 6'd0;
  localparam logic [5:0] SYM_A      = 6'd1;
  localparam logic [5:0] SYM_E      = 6'd5;
  localparam logic [5:0] SYM_Z      = 6'd26;
  localparam logic [5:0] SYM_DIGIT0 = 6'd27;
  localparam logic [5:0] SYM_DIGIT9 = 6'd36;
  localparam logic [5:0] SYM_ERR    = 6'd40;

  localparam int unsigned N_CODED = 36;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_EMIT
  } state_e;

  // {length[2:0], code[4:0]}: code is right-aligned in sending order, 1 = dash
  function automatic logic [7:0] morse_code(input logic [5:0] idx);
    case (idx)
      6'd1:  return {3'd2, 5'b00001};
      6'd2:  return {3'd4, 5'b01000};
      6'd3:  return {3'd4, 5'b01010};
      6'd4:  return {3'd3, 5'b00100};
      6'd5:  return {3'd1, 5'b00000};
      6'd6:  return {3'd4, 5'b00010};
      6'd7:  return {3'd3, 5'b00110};
      6'd8:  return {3'd4, 5'b00000};
      6'd9:  return {3'd2, 5'b00000};
      6'd10: return {3'd4, 5'b00111};
      6'd11: return {3'd3, 5'b00101};
      6'd12: return {3'd4, 5'b00100};
      6'd13: return {3'd2, 5'b00011};
      6'd14: return {3'd2, 5'b00010};
      6'd15: return {3'd3, 5'b00111};
      6'd16: return {3'd4, 5'b00110};
      6'd17: return {3'd4, 5'b01101};
      6'd18: return {3'd3, 5'b00010};
      6'd19: return {3'd3, 5'b00000};
      6'd20: return {3'd1, 5'b00001};
      6'd21: return {3'd3, 5'b00001};
      6'd22: return {3'd4, 5'b00001};
      6'd23: return {3'd3, 5'b00011};
      6'd24: return {3'd4, 5'b01001};
      6'd25: return {3'd4, 5'b01011};
      6'd26: return {3'd4, 5'b01100};
      6'd27: return {3'd5, 5'b11111};
      6'd28: return {3'd5, 5'b01111};
      6'd29: return {3'd5, 5'b00111};
      6'd30: return {3'd5, 5'b00011};
      6'd31: return {3'd5, 5'b00001};
      6'd32: return {3'd5, 5'b00000};
      6'd33: return {3'd5, 5'b10000};
      6'd34: return {3'd5, 5'b11000};
      6'd35: return {3'd5, 5'b11100};
      6'd36: return {3'd5, 5'b11110};
      default: return '0;
    endcase
  endfunction

  // Element i of the collected pattern sits in bit i, so table codes are bit-reversed to match
  function automatic logic [5:0] morse_lookup(input logic [2:0] elem_cnt, input logic [4:0] pattern);
    logic [5:0] result;
    logic [7:0] code;
    logic [2:0] len;
    logic [4:0] pat;
    result = SYM_ERR;
    for (int unsigned i = 1; i <= N_CODED; i++) begin
      code = morse_code(6'(i));
      len  = code[7:5];
      pat  = '0;
      for (int unsigned j = 0; j < 5; j++) begin
        if (3'(j) < len) pat[j] = code[3'(len - 3'(j) - 3'd1)];
      end
      if (len == elem_cnt && pat == pattern) result = 6'(i);
    end
    return result;
  endfunction

endpackage

// File: rtl/morse_key_decoder_debouncer.sv
// Two-flop synchronizer followed by a symmetric stable-count debouncer.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic key_db_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic          sync1_q, sync2_q, key_db_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      key_db_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      if (sync2_q != key_db_q) begin
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          key_db_q <= ~key_db_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign key_db_o = key_db_q;

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key decoder: times debounced marks/spaces, collects dots/dashes and emits a
// registered symbol index for the seven-segment decoder at each inter-letter gap.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES      = 12_500_000,
  parameter int unsigned DEBOUNCE_CYCLES  = 500_000,
  parameter int unsigned DASH_UNITS       = 2,
  parameter int unsigned LETTER_GAP_UNITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  input  logic       clear,
  output logic [5:0] sym,
  output logic       disp_en,
  output logic       sym_valid,
  output logic       key_led
);

  localparam int unsigned PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  // The edge cycle is already the first cycle of the new interval
  localparam logic [PW-1:0] PRESC_RESTART = (UNIT_CYCLES > 1) ? PW'(1) : '0;

  logic          key_db, key_prev_q;
  logic          key_rise, key_fall;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    units_q, units_d;
  state_e        state_q;
  logic [4:0]    pattern_q;
  logic [2:0]    elem_cnt_q;
  logic          ovf_q;
  logic [5:0]    sym_q;
  logic          disp_en_q, sym_valid_q;
  logic          is_dash;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_i   (key_in),
    .key_db_o(key_db)
  );

  assign key_rise = key_db & ~key_prev_q;
  assign key_fall = ~key_db & key_prev_q;
  assign is_dash  = (units_q >= 3'(DASH_UNITS));

  always_comb begin
    presc_d = presc_q;
    units_d = units_q;
    if (key_rise || key_fall) begin
      presc_d = PRESC_RESTART;
      units_d = '0;
    end else if (presc_q == PW'(UNIT_CYCLES - 1)) begin
      presc_d = '0;
      if (units_q != 3'd7) units_d = units_q + 3'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev_q  <= 1'b0;
      presc_q     <= '0;
      units_q     <= '0;
      state_q     <= ST_IDLE;
      pattern_q   <= '0;
      elem_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      sym_q       <= SYM_BLANK;
      disp_en_q   <= 1'b0;
      sym_valid_q <= 1'b0;
    end else begin
      key_prev_q  <= key_db;
      presc_q     <= presc_d;
      units_q     <= units_d;
      sym_valid_q <= 1'b0;
      if (clear) begin
        state_q    <= ST_IDLE;
        sym_q      <= SYM_BLANK;
        disp_en_q  <= 1'b0;
        pattern_q  <= '0;
        elem_cnt_q <= '0;
        ovf_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (key_rise) state_q <= ST_MARK;
          end
          ST_MARK: begin
            if (key_fall) begin
              if (elem_cnt_q < 3'd5) begin
                pattern_q  <= pattern_q | (5'(is_dash) << elem_cnt_q);
                elem_cnt_q <= elem_cnt_q + 3'd1;
              end else begin
                ovf_q <= 1'b1;
              end
              state_q <= ST_SPACE;
            end
          end
          ST_SPACE: begin
            // Entering EMIT on the edge that completes the last gap unit
            if (key_rise) state_q <= ST_MARK;
            else if (units_d == 3'(LETTER_GAP_UNITS)) state_q <= ST_EMIT;
          end
          ST_EMIT: begin
            sym_q       <= ovf_q ? SYM_ERR : morse_lookup(elem_cnt_q, pattern_q);
            sym_valid_q <= 1'b1;
            disp_en_q   <= 1'b1;
            pattern_q   <= '0;
            elem_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            state_q     <= key_db ? ST_MARK : ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign sym       = sym_q;
  assign disp_en   = disp_en_q;
  assign sym_valid = sym_valid_q;
  assign key_led   = key_db;

endmodule
